// File: rtl/bp_fe_queue_sender.sv
// FE-side producer of the FE->BE queue: packs fetches and exceptions into
// queue messages, buffers them in a small circular FIFO and offers the head to the BE.
module bp_fe_queue_sender #(
    parameter int vaddr_width_p               = 39,
    parameter int branch_metadata_fwd_width_p = 36,
    parameter int els_p                       = 2,
    localparam int fe_queue_width_lp          = 2 + vaddr_width_p + 32 + branch_metadata_fwd_width_p
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic                                   flush_i,

    input  logic                                   fetch_v_i,
    input  logic [vaddr_width_p-1:0]               fetch_pc_i,
    input  logic [31:0]                            fetch_instr_i,
    input  logic [branch_metadata_fwd_width_p-1:0] fetch_br_metadata_i,

    input  logic                                   exc_v_i,
    input  logic [vaddr_width_p-1:0]               exc_vaddr_i,
    input  logic [2:0]                             exc_code_i,

    output logic                                   ready_o,
    output logic                                   exc_pending_o,

    output logic [fe_queue_width_lp-1:0]           fe_queue_o,
    output logic                                   fe_queue_v_o,
    input  logic                                   fe_queue_ready_i
);

    localparam int ptr_width_lp = $clog2(els_p);
    localparam int cnt_width_lp = ptr_width_lp + 1;
    localparam logic [cnt_width_lp-1:0] els_lp = cnt_width_lp'(els_p);

    typedef enum logic [1:0] {
        e_fe_fetch     = 2'd0,
        e_fe_exception = 2'd1
    } bp_fe_queue_type_e;

    typedef struct packed {
        logic [vaddr_width_p-1:0]               pc;
        logic [31:0]                            instr;
        logic [branch_metadata_fwd_width_p-1:0] branch_metadata_fwd;
    } bp_fe_fetch_s;

    // Padding makes the exception view exactly as wide as the fetch view.
    typedef struct packed {
        logic [vaddr_width_p-1:0]                vaddr;
        logic [2:0]                              exception_code;
        logic [branch_metadata_fwd_width_p+28:0] padding;
    } bp_fe_exception_s;

    typedef union packed {
        bp_fe_fetch_s     fetch;
        bp_fe_exception_s exception;
    } bp_fe_msg_u;

    typedef struct packed {
        bp_fe_queue_type_e msg_type;
        bp_fe_msg_u        msg;
    } bp_fe_queue_s;

    typedef enum logic {
        e_run   = 1'b0,
        e_stall = 1'b1
    } state_e;

    state_e                      state_r, state_n;
    logic [cnt_width_lp-1:0]     count_r;
    logic [ptr_width_lp-1:0]     rptr_r, wptr_r;
    logic [fe_queue_width_lp-1:0] mem [els_p];
    bp_fe_queue_s                enq_msg;
    logic                        enq, deq;

    assign ready_o       = (state_r == e_run) && (count_r < els_lp);
    assign exc_pending_o = (state_r == e_stall);
    assign fe_queue_v_o  = (count_r != '0);
    assign fe_queue_o    = fe_queue_v_o ? mem[rptr_r] : '0;

    assign enq = ready_o & ~flush_i & (exc_v_i | fetch_v_i);
    assign deq = fe_queue_v_o & fe_queue_ready_i & ~flush_i;

    // An exception wins over a same-cycle fetch; the fetch is simply dropped.
    always_comb begin
        enq_msg = '0;
        if (exc_v_i) begin
            enq_msg.msg_type                     = e_fe_exception;
            enq_msg.msg.exception.vaddr          = exc_vaddr_i;
            enq_msg.msg.exception.exception_code = exc_code_i;
        end else begin
            enq_msg.msg_type                      = e_fe_fetch;
            enq_msg.msg.fetch.pc                  = fetch_pc_i;
            enq_msg.msg.fetch.instr               = fetch_instr_i;
            enq_msg.msg.fetch.branch_metadata_fwd = fetch_br_metadata_i;
        end
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            e_run:   if (enq && exc_v_i) state_n = e_stall;
            e_stall: if (flush_i)        state_n = e_run;
            default: state_n = e_run;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_run;
            count_r <= '0;
            rptr_r  <= '0;
            wptr_r  <= '0;
        end else if (flush_i) begin
            state_r <= e_run;
            count_r <= '0;
            rptr_r  <= '0;
            wptr_r  <= '0;
        end else begin
            state_r <= state_n;
            if (enq) wptr_r <= wptr_r + ptr_width_lp'(1);
            if (deq) rptr_r <= rptr_r + ptr_width_lp'(1);
            case ({enq, deq})
                2'b10:   count_r <= count_r + cnt_width_lp'(1);
                2'b01:   count_r <= count_r - cnt_width_lp'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage is deliberately left unreset; the output mux hides stale entries.
    always_ff @(posedge clk_i) begin
        if (enq) mem[wptr_r] <= enq_msg;
    end

endmodule

// File: tb/tb_bp_fe_queue_sender.sv
// Directed bench for bp_fe_queue_sender: expected messages go into a scoreboard
// queue and a negedge monitor checks every accepted handshake against it.
module tb_bp_fe_queue_sender;

    localparam int VW = 39;
    localparam int BM = 36;
    localparam int QW = 2 + VW + 32 + BM;

    logic          clk_i;
    logic          reset_n_i;
    logic          flush_i;
    logic          fetch_v_i;
    logic [VW-1:0] fetch_pc_i;
    logic [31:0]   fetch_instr_i;
    logic [BM-1:0] fetch_br_metadata_i;
    logic          exc_v_i;
    logic [VW-1:0] exc_vaddr_i;
    logic [2:0]    exc_code_i;
    logic          ready_o;
    logic          exc_pending_o;
    logic [QW-1:0] fe_queue_o;
    logic          fe_queue_v_o;
    logic          fe_queue_ready_i;

    int vectors     = 0;
    int miscompares = 0;
    logic [QW-1:0] sb[$];

    bp_fe_queue_sender #(
        .vaddr_width_p              (VW),
        .branch_metadata_fwd_width_p(BM),
        .els_p                      (2)
    ) dut (
        .clk_i              (clk_i),
        .reset_n_i          (reset_n_i),
        .flush_i            (flush_i),
        .fetch_v_i          (fetch_v_i),
        .fetch_pc_i         (fetch_pc_i),
        .fetch_instr_i      (fetch_instr_i),
        .fetch_br_metadata_i(fetch_br_metadata_i),
        .exc_v_i            (exc_v_i),
        .exc_vaddr_i        (exc_vaddr_i),
        .exc_code_i         (exc_code_i),
        .ready_o            (ready_o),
        .exc_pending_o      (exc_pending_o),
        .fe_queue_o         (fe_queue_o),
        .fe_queue_v_o       (fe_queue_v_o),
        .fe_queue_ready_i   (fe_queue_ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] instr_of(input logic [VW-1:0] pc);
        return 32'h0000_0013 ^ {pc[15:0], pc[15:0]};
    endfunction

    function automatic logic [BM-1:0] meta_of(input logic [VW-1:0] pc);
        return {pc[BM-1:0]} ^ {BM{1'b1}};
    endfunction

    function automatic logic [QW-1:0] fetch_msg(input logic [VW-1:0] pc);
        return {2'b00, pc, instr_of(pc), meta_of(pc)};
    endfunction

    function automatic logic [QW-1:0] exc_msg(input logic [VW-1:0] va, input logic [2:0] code);
        return {2'b01, va, code, {(BM+29){1'b0}}};
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_stimulus(input logic fv, input logic [VW-1:0] pc,
                                  input logic ev, input logic [VW-1:0] va,
                                  input logic [2:0] code);
        fetch_v_i           = fv;
        fetch_pc_i          = pc;
        fetch_instr_i       = instr_of(pc);
        fetch_br_metadata_i = meta_of(pc);
        exc_v_i             = ev;
        exc_vaddr_i         = va;
        exc_code_i          = code;
    endtask

    task automatic check_output(input string name, input logic [QW-1:0] act, input logic [QW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake the BE would accept must match the scoreboard head.
    always @(negedge clk_i) begin
        if (reset_n_i && fe_queue_v_o && fe_queue_ready_i && !flush_i) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_msg: got %0h, expected none", fe_queue_o);
            end else begin
                check_output("deq_msg", fe_queue_o, sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n_i        = 1'b1;
        flush_i          = 1'b0;
        fe_queue_ready_i = 1'b0;
        apply_stimulus(1'b0, '0, 1'b0, '0, 3'd0);
        #1 reset_n_i = 1'b0;
        #1;
        check_output("rst_v",       QW'(fe_queue_v_o),  QW'(0));
        check_output("rst_o",       fe_queue_o,         '0);
        check_output("rst_ready",   QW'(ready_o),       QW'(1));
        check_output("rst_pending", QW'(exc_pending_o), QW'(0));
        step();
        step();
        reset_n_i = 1'b1;
        step();

        $display("[TB] fill/drain");
        apply_stimulus(1'b1, 39'h100, 1'b0, '0, 3'd0); sb.push_back(fetch_msg(39'h100));
        step();
        apply_stimulus(1'b1, 39'h104, 1'b0, '0, 3'd0); sb.push_back(fetch_msg(39'h104));
        step();
        check_output("full_ready", QW'(ready_o),      QW'(0));
        check_output("full_v",     QW'(fe_queue_v_o), QW'(1));
        apply_stimulus(1'b1, 39'h108, 1'b0, '0, 3'd0);
        step();
        check_output("full_ready_hold", QW'(ready_o), QW'(0));
        apply_stimulus(1'b0, '0, 1'b0, '0, 3'd0);
        fe_queue_ready_i = 1'b1;
        step();
        check_output("drain1_ready", QW'(ready_o),      QW'(1));
        check_output("drain1_v",     QW'(fe_queue_v_o), QW'(1));
        step();
        check_output("drained_v",     QW'(fe_queue_v_o), QW'(0));
        check_output("drained_ready", QW'(ready_o),      QW'(1));
        fe_queue_ready_i = 1'b0;

        $display("[TB] exception priority");
        apply_stimulus(1'b1, 39'h2000, 1'b1, 39'h2000, 3'd3); sb.push_back(exc_msg(39'h2000, 3'd3));
        step();
        check_output("exc_pending", QW'(exc_pending_o), QW'(1));
        check_output("exc_ready",   QW'(ready_o),       QW'(0));
        apply_stimulus(1'b1, 39'h2004, 1'b0, '0, 3'd0);
        step();
        step();
        check_output("exc_v_hold", QW'(fe_queue_v_o), QW'(1));
        apply_stimulus(1'b0, '0, 1'b0, '0, 3'd0);
        fe_queue_ready_i = 1'b1;
        step();
        fe_queue_ready_i = 1'b0;
        check_output("stall_empty_v",   QW'(fe_queue_v_o),  QW'(0));
        check_output("stall_pending",   QW'(exc_pending_o), QW'(1));
        check_output("stall_ready",     QW'(ready_o),       QW'(0));
        apply_stimulus(1'b1, 39'h2008, 1'b0, '0, 3'd0);
        step();
        check_output("stall_drop_v", QW'(fe_queue_v_o), QW'(0));
        apply_stimulus(1'b0, '0, 1'b0, '0, 3'd0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check_output("unstall_pending", QW'(exc_pending_o), QW'(0));
        check_output("unstall_ready",   QW'(ready_o),       QW'(1));

        $display("[TB] flush mid-stream");
        apply_stimulus(1'b1, 39'h200, 1'b0, '0, 3'd0); sb.push_back(fetch_msg(39'h200));
        step();
        apply_stimulus(1'b0, '0, 1'b1, 39'h204, 3'd2); sb.push_back(exc_msg(39'h204, 3'd2));
        step();
        check_output("pre_flush_pending", QW'(exc_pending_o), QW'(1));
        check_output("pre_flush_v",       QW'(fe_queue_v_o),  QW'(1));
        apply_stimulus(1'b1, 39'h300, 1'b0, '0, 3'd0);
        fe_queue_ready_i = 1'b1;
        flush_i = 1'b1;
        sb.delete();
        step();
        flush_i = 1'b0;
        fe_queue_ready_i = 1'b0;
        apply_stimulus(1'b0, '0, 1'b0, '0, 3'd0);
        check_output("flush_v",       QW'(fe_queue_v_o),  QW'(0));
        check_output("flush_o",       fe_queue_o,         '0);
        check_output("flush_pending", QW'(exc_pending_o), QW'(0));
        check_output("flush_ready",   QW'(ready_o),       QW'(1));
        step();
        check_output("flush_no_300", QW'(fe_queue_v_o), QW'(0));

        $display("[TB] streaming wrap");
        fe_queue_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b1, VW'(4 * i), 1'b0, '0, 3'd0);
            sb.push_back(fetch_msg(VW'(4 * i)));
            if (i == 0) check_output("no_bypass_v", QW'(fe_queue_v_o), QW'(0));
            step();
            check_output("stream_v",     QW'(fe_queue_v_o), QW'(1));
            check_output("stream_ready", QW'(ready_o),      QW'(1));
        end
        apply_stimulus(1'b0, '0, 1'b0, '0, 3'd0);
        step();
        check_output("stream_done_v", QW'(fe_queue_v_o), QW'(0));
        fe_queue_ready_i = 1'b0;

        $display("[TB] simultaneous enq/deq");
        apply_stimulus(1'b1, 39'h500, 1'b0, '0, 3'd0); sb.push_back(fetch_msg(39'h500));
        step();
        apply_stimulus(1'b1, 39'h504, 1'b0, '0, 3'd0); sb.push_back(fetch_msg(39'h504));
        fe_queue_ready_i = 1'b1;
        step();
        fe_queue_ready_i = 1'b0;
        apply_stimulus(1'b0, '0, 1'b0, '0, 3'd0);
        check_output("sim_v",     QW'(fe_queue_v_o), QW'(1));
        check_output("sim_ready", QW'(ready_o),      QW'(1));
        check_output("sim_head",  fe_queue_o,        fetch_msg(39'h504));
        fe_queue_ready_i = 1'b1;
        step();
        fe_queue_ready_i = 1'b0;
        check_output("sim_drained_v", QW'(fe_queue_v_o), QW'(0));

        $display("[TB] async reset");
        apply_stimulus(1'b1, 39'h600, 1'b0, '0, 3'd0);
        step();
        apply_stimulus(1'b1, 39'h604, 1'b0, '0, 3'd0);
        step();
        apply_stimulus(1'b0, '0, 1'b0, '0, 3'd0);
        check_output("pre_rst_ready", QW'(ready_o), QW'(0));
        #2;
        reset_n_i = 1'b0;
        #1;
        check_output("async_rst_v", QW'(fe_queue_v_o), QW'(0));
        check_output("async_rst_o", fe_queue_o,        '0);
        step();
        reset_n_i = 1'b1;
        #1;
        check_output("post_rst_ready", QW'(ready_o),      QW'(1));
        check_output("post_rst_v",     QW'(fe_queue_v_o), QW'(0));
        apply_stimulus(1'b1, 39'h700, 1'b0, '0, 3'd0); sb.push_back(fetch_msg(39'h700));
        fe_queue_ready_i = 1'b1;
        step();
        apply_stimulus(1'b0, '0, 1'b0, '0, 3'd0);
        step();
        step();
        fe_queue_ready_i = 1'b0;

        check_output("sb_empty", QW'(sb.size()), QW'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bp_fe_queue_sender.md
Name: bp_fe_queue_sender

Overview:
- FE-side producer of the FE→BE queue interface; the BE issue queue and scheduler consume its messages.
- Packs fetched instructions and FE exceptions into bp_fe_queue_s messages (e_fe_fetch / e_fe_exception).
- Buffers messages in a small circular FIFO and drives a valid/ready handshake toward the BE.
- After an exception it stalls all further enqueues until the FE redirects via flush.

Parameters:
bp_params_p, e_bp_default_cfg, processor configuration; supplies vaddr_width_p, branch_metadata_fwd_width_p.
els_p, 2, FIFO depth in messages; power of two, ≥2.
fe_queue_width_lp, `bp_fe_queue_width(vaddr_width_p, branch_metadata_fwd_width_p), packed message width (localparam).

Ports:
clk_i  in  1  clock; all state updates on rising edge.
reset_n_i  in  1  asynchronous, active-low reset.
flush_i  in  1  FE redirect/command; discards all buffered and incoming messages.
fetch_v_i  in  1  fetched instruction valid.
fetch_pc_i  in  vaddr_width_p  instruction PC.
fetch_instr_i  in  32  instruction bits.
fetch_br_metadata_i  in  branch_metadata_fwd_width_p  branch metadata forwarded to the BE.
exc_v_i  in  1  FE exception valid.
exc_vaddr_i  in  vaddr_width_p  faulting vaddr.
exc_code_i  in  3  bp_fe_exception_code_e (access fault, misaligned, page fault, itlb miss, icache miss).
ready_o  out  1  sender can accept a fetch or exception this cycle.
exc_pending_o  out  1  sender is in e_stall.
fe_queue_o  out  fe_queue_width_lp  head message (bp_fe_queue_s).
fe_queue_v_o  out  1  head message valid.
fe_queue_ready_i  in  1  BE accepts the head message.

Behaviour:
- Reset (reset_n_i low, asynchronous): count=0, rptr=wptr=0, state=e_run. Outputs: fe_queue_v_o=0, fe_queue_o='0, ready_o=1, exc_pending_o=0. Storage contents are not reset.
- State machine has two states:
  - e_run → e_stall when an exception is enqueued.
  - e_stall → e_run when flush_i is high.
  - flush_i in e_run keeps the state at e_run.
- ready_o = (state==e_run) & (count<els_p). It depends only on registered state and has no combinational path from fe_queue_ready_i.
- Enqueue happens when ready_o & ~flush_i & (exc_v_i | fetch_v_i).
  - If exc_v_i is high, exc_v_i wins. Write msg_type=e_fe_exception, vaddr, exception_code. The same-cycle fetch is dropped.
  - Otherwise write msg_type=e_fe_fetch, pc, instr, branch_metadata_fwd.
  - Unused union bits are written '0.
  - wptr increments modulo els_p.
- fetch_v_i or exc_v_i asserted while ready_o is low is dropped. Upstream must hold the input or refetch.
- fe_queue_v_o = (count!=0). fe_queue_o = mem[rptr] when valid, else '0.
- Dequeue happens when fe_queue_v_o & fe_queue_ready_i & ~flush_i. rptr increments modulo els_p.
- Simultaneous enqueue and dequeue leaves count unchanged; both pointers advance.
- An enqueued message reaches fe_queue_v_o no earlier than the next cycle (1-cycle minimum latency). There is no bypass.
- Full (count==els_p): ready_o=0. A dequeue that cycle frees a slot, and ready_o rises the following cycle.
- Wrap-around: pointers are log2(els_p) bits and wrap naturally. Count is a separate log2(els_p)+1-bit register.
- flush_i has the highest priority:
  - Next cycle: count=0, rptr=wptr=0, state=e_run.
  - Same-cycle enqueue and dequeue are suppressed.
  - fe_queue_v_o=0 from the next cycle.
  - fe_queue_v_o may still be high during the flush cycle itself. The BE must ignore a handshake in that cycle, and the sender does not count it.
- In e_stall, buffered messages continue to drain normally; only enqueue is blocked.
- Order is strictly FIFO. The exception message is always the last message before e_stall.

Test Plan:
- Fill/drain: fe_queue_ready_i=0; fetch pcs 0x100, 0x104. Expect ready_o=0 after 2 enqueues and the third fetch dropped. Then set fe_queue_ready_i=1: 0x100 then 0x104 dequeue in order, fe_queue_v_o falls, ready_o=1.
- Exception priority: same cycle exc_v_i=1 (vaddr 0x2000, e_itlb_miss) and fetch_v_i=1 (pc 0x2000). Expect only the exception message, exc_pending_o=1 next cycle, and later fetches dropped until flush_i.
- Flush mid-stream: 2 messages buffered in e_stall; pulse flush_i with fetch_v_i=1 pc 0x300. Expect fe_queue_v_o=0 next cycle, 0x300 not enqueued, exc_pending_o=0, ready_o=1.
- Streaming wrap: fe_queue_ready_i=1, continuous fetches pc 0x0, 0x4, … for 10 cycles. Expect 1-cycle latency, count ≤1, all 10 pcs delivered in order, pointers wrapping ≥4 times.
- Simultaneous enqueue/dequeue at count=1: expect count stays 1 and order preserved.
- Asynchronous reset asserted mid-cycle with count=2: expect fe_queue_v_o=0 and fe_queue_o='0 immediately, before the next clock edge; ready_o=1 after release.
